// File: rtl/kpu_useq_pkg.sv
// Shared encodings for the KPU microcode sequencer: microword fields, sequencing
// ops, branch conditions and FSM states.
package kpu_useq_pkg;

    typedef enum logic [1:0] {
        SEQ_NEXT   = 2'd0,
        SEQ_END    = 2'd1,
        SEQ_BRANCH = 2'd2,
        SEQ_WAIT   = 2'd3
    } seq_t;

    typedef enum logic [1:0] {
        COND_ALWAYS = 2'd0,
        COND_Z      = 2'd1,
        COND_C      = 2'd2,
        COND_N      = 2'd3
    } cond_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam int SEQ_LSB    = 0;
    localparam int COND_LSB   = 2;
    localparam int TARGET_LSB = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    // SRC sits directly above TARGET; CTRL takes everything above SRC.
    function automatic int src_lsb(input int step_bits);
        return TARGET_LSB + step_bits;
    endfunction

endpackage

// File: rtl/kpu_useq_if.sv
// Opcode handshake, microcode SRAM port, MLU flags and bus-control outputs of
// the sequencer, bundled so the core and its environment share one definition.
interface kpu_useq_if #(
    parameter int OP_BITS     = 6,
    parameter int STEP_BITS   = 4,
    parameter int UWORD_WIDTH = 32,
    parameter int NUM_SRC     = 4,
    parameter int SRC_BITS    = $clog2(NUM_SRC + 1),
    parameter int CTRL_WIDTH  = UWORD_WIDTH - 4 - STEP_BITS - SRC_BITS
);
    logic [OP_BITS-1:0]           op;
    logic                         op_valid;
    logic                         op_ready;
    logic [OP_BITS+STEP_BITS-1:0] uc_addr;
    logic [UWORD_WIDTH-1:0]       uc_data;
    logic [2:0]                   flags;
    logic                         wait_done;
    logic [NUM_SRC-1:0]           bus_n_oe;
    logic [CTRL_WIDTH-1:0]        ctrl;
    logic                         busy;
    logic                         fault;

    modport slave (
        input  op, op_valid, uc_data, flags, wait_done,
        output op_ready, uc_addr, bus_n_oe, ctrl, busy, fault
    );

    modport master (
        output op, op_valid, uc_data, flags, wait_done,
        input  op_ready, uc_addr, bus_n_oe, ctrl, busy, fault
    );
endinterface

// File: rtl/kpu_useq_decode.sv
// Combinational microword decode: bus enables, control passthrough, branch
// condition and source-select validity.
module kpu_useq_decode
    import kpu_useq_pkg::*;
#(
    parameter int STEP_BITS   = 4,
    parameter int UWORD_WIDTH = 32,
    parameter int NUM_SRC     = 4,
    parameter int SRC_BITS    = $clog2(NUM_SRC + 1),
    parameter int CTRL_WIDTH  = UWORD_WIDTH - 4 - STEP_BITS - SRC_BITS
) (
    input  logic [UWORD_WIDTH-1:0] uword,
    input  logic [2:0]             flags,
    input  state_t                 state,
    output logic [NUM_SRC-1:0]     bus_n_oe,
    output logic [CTRL_WIDTH-1:0]  ctrl,
    output seq_t                   seq,
    output logic [STEP_BITS-1:0]   target,
    output logic                   cond_true,
    output logic                   src_invalid
);
    localparam int SRC_LSB = src_lsb(STEP_BITS);

    logic [SRC_BITS-1:0] src;
    cond_t               cond;
    logic                in_exec;
    logic                drive;

    assign seq         = seq_t'(uword[SEQ_LSB +: 2]);
    assign cond        = cond_t'(uword[COND_LSB +: 2]);
    assign target      = uword[TARGET_LSB +: STEP_BITS];
    assign src         = uword[SRC_LSB +: SRC_BITS];
    assign src_invalid = (int'(src) > NUM_SRC);
    assign in_exec     = (state == ST_EXEC);
    assign drive       = in_exec && !src_invalid;

    // Each enable compares against a distinct code of one field, so no two can be low together.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_oe
            assign bus_n_oe[gi] = ~(drive && (int'(src) == gi + 1));
        end
    endgenerate

    assign ctrl = in_exec ? uword[UWORD_WIDTH-1 -: CTRL_WIDTH] : '0;

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_ALWAYS: cond_true = 1'b1;
            COND_Z:      cond_true = flags[FLAG_Z];
            COND_C:      cond_true = flags[FLAG_C];
            COND_N:      cond_true = flags[FLAG_N];
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/kpu_useq.sv
// KPU microcode sequencer: walks {opcode, step} through microcode SRAM and
// drives one-hot bus enables plus control lines from the registered microword.
module kpu_useq
    import kpu_useq_pkg::*;
#(
    parameter int OP_BITS     = 6,
    parameter int STEP_BITS   = 4,
    parameter int UWORD_WIDTH = 32,
    parameter int NUM_SRC     = 4,
    parameter int SRC_BITS    = $clog2(NUM_SRC + 1),
    parameter int CTRL_WIDTH  = UWORD_WIDTH - 4 - STEP_BITS - SRC_BITS
) (
    input logic       clk,
    input logic       rst_n,
    kpu_useq_if.slave bus
);
    state_t                 state_reg, state_next;
    logic [OP_BITS-1:0]     op_reg, op_next;
    logic [STEP_BITS-1:0]   step_reg, step_next;
    logic [UWORD_WIDTH-1:0] uword_reg, uword_next;
    logic                   fault_reg, fault_next;

    seq_t                   dec_seq;
    logic [STEP_BITS-1:0]   dec_target;
    logic                   dec_cond_true;
    logic                   dec_src_invalid;
    logic                   want_inc;

    kpu_useq_decode #(
        .STEP_BITS   (STEP_BITS),
        .UWORD_WIDTH (UWORD_WIDTH),
        .NUM_SRC     (NUM_SRC),
        .SRC_BITS    (SRC_BITS),
        .CTRL_WIDTH  (CTRL_WIDTH)
    ) u_decode (
        .uword       (uword_reg),
        .flags       (bus.flags),
        .state       (state_reg),
        .bus_n_oe    (bus.bus_n_oe),
        .ctrl        (bus.ctrl),
        .seq         (dec_seq),
        .target      (dec_target),
        .cond_true   (dec_cond_true),
        .src_invalid (dec_src_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            op_reg    <= '0;
            step_reg  <= '0;
            uword_reg <= '0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            op_reg    <= op_next;
            step_reg  <= step_next;
            uword_reg <= uword_next;
            fault_reg <= fault_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        op_next    = op_reg;
        step_next  = step_reg;
        uword_next = uword_reg;
        fault_next = fault_reg;
        want_inc   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    op_next    = bus.op;
                    step_next  = '0;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                uword_next = bus.uc_data;
                state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_src_invalid) begin
                    fault_next = 1'b1;
                    state_next = ST_HALT;
                end else begin
                    case (dec_seq)
                        SEQ_NEXT:   want_inc = 1'b1;
                        SEQ_END:    state_next = ST_IDLE;
                        SEQ_BRANCH: begin
                            if (dec_cond_true) begin
                                step_next  = dec_target;
                                state_next = ST_FETCH;
                            end else begin
                                want_inc = 1'b1;
                            end
                        end
                        SEQ_WAIT:   want_inc = bus.wait_done;
                        default:    want_inc = 1'b0;
                    endcase
                end
                // Running off the last step of an opcode is a microcode bug, never a wrap.
                if (want_inc) begin
                    if (&step_reg) begin
                        fault_next = 1'b1;
                        state_next = ST_HALT;
                    end else begin
                        step_next  = step_reg + STEP_BITS'(1);
                        state_next = ST_FETCH;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.op_ready = (state_reg == ST_IDLE);
    assign bus.busy     = (state_reg != ST_IDLE);
    assign bus.uc_addr  = {op_reg, step_reg};
    assign bus.fault    = fault_reg;

`ifdef FORMAL
    a_one_driver: assert property (@(posedge clk) $countones(~bus.bus_n_oe) <= 1);
`endif

endmodule
